// File: rtl/screen_sequencer.sv
// Top-level screen sequencer: orders full-screen draws, maze drawing, gameplay,
// level progression and the timed win/game-over screens.
module screen_sequencer #(
    parameter int unsigned HOLD_CYCLES = 100000000,
    parameter int unsigned NUM_LEVELS  = 3,
    parameter int unsigned GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startKey,
    input  logic       screenDone,
    input  logic       mazeDone,
    input  logic       playerWon,
    input  logic       playerDead,
    output logic       drawStart,
    output logic       drawClear,
    output logic       drawGameOver,
    output logic       drawWinner,
    output logic       drawMaze,
    output logic       plotEn,
    output logic       gameActive,
    output logic [1:0] level
);

    localparam int unsigned HOLD_W  = 27;
    localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned LEVEL_W = 2;

    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'((NUM_LEVELS > 0) ? NUM_LEVELS - 1 : 0);

    typedef enum logic [3:0] {
        S_GAP,
        S_START_DRAW,
        S_WAIT_KEY,
        S_CLEAR,
        S_MAZE,
        S_PLAY,
        S_WIN_DRAW,
        S_OVER_DRAW,
        S_HOLD
    } state_e;

    state_e               state_q, state_d;
    state_e               pend_q, pend_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic                 won_q, won_d;

    logic                 key_meta_q, key_sync_q, key_prev_q;
    logic                 key_evt;

    logic                 draw_start_q, draw_start_d;
    logic                 draw_clear_q, draw_clear_d;
    logic                 draw_over_q, draw_over_d;
    logic                 draw_win_q, draw_win_d;
    logic                 draw_maze_q, draw_maze_d;
    logic                 game_active_q, game_active_d;

    // Two-flop synchronizer plus a third flop for rising-edge detection.
    assign key_evt = key_sync_q & ~key_prev_q;

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_GAP;
            pend_q        <= S_START_DRAW;
            gap_q         <= '0;
            hold_q        <= '0;
            level_q       <= '0;
            won_q         <= 1'b0;
            key_meta_q    <= 1'b0;
            key_sync_q    <= 1'b0;
            key_prev_q    <= 1'b0;
            draw_start_q  <= 1'b0;
            draw_clear_q  <= 1'b0;
            draw_over_q   <= 1'b0;
            draw_win_q    <= 1'b0;
            draw_maze_q   <= 1'b0;
            game_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            gap_q         <= gap_d;
            hold_q        <= hold_d;
            level_q       <= level_d;
            won_q         <= won_d;
            key_meta_q    <= startKey;
            key_sync_q    <= key_meta_q;
            key_prev_q    <= key_sync_q;
            draw_start_q  <= draw_start_d;
            draw_clear_q  <= draw_clear_d;
            draw_over_q   <= draw_over_d;
            draw_win_q    <= draw_win_d;
            draw_maze_q   <= draw_maze_d;
            game_active_q <= game_active_d;
        end
    end

    // Next-state logic; every screen change passes through GAP so done can drop.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        level_d = level_q;
        won_d   = won_q;
        case (state_q)
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = pend_q;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_START_DRAW: begin
                if (screenDone) begin
                    state_d = S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                if (key_evt) begin
                    level_d = '0;
                    state_d = S_GAP;
                    pend_d  = S_CLEAR;
                    gap_d   = '0;
                end
            end
            S_CLEAR: begin
                if (screenDone) begin
                    state_d = S_GAP;
                    pend_d  = S_MAZE;
                    gap_d   = '0;
                end
            end
            S_MAZE: begin
                if (mazeDone) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (playerWon) begin
                    state_d = S_GAP;
                    pend_d  = S_WIN_DRAW;
                    gap_d   = '0;
                end else if (playerDead) begin
                    state_d = S_GAP;
                    pend_d  = S_OVER_DRAW;
                    gap_d   = '0;
                end
            end
            S_WIN_DRAW: begin
                if (screenDone) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                    won_d   = 1'b1;
                end
            end
            S_OVER_DRAW: begin
                if (screenDone) begin
                    state_d = S_HOLD;
                    hold_d  = HOLD_LOAD;
                    won_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (key_evt || (hold_q == '0)) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    if (won_q && (level_q < LEVEL_LAST)) begin
                        level_d = level_q + LEVEL_W'(1);
                        pend_d  = S_CLEAR;
                    end else begin
                        level_d = '0;
                        pend_d  = S_START_DRAW;
                    end
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_GAP;
                pend_d  = S_START_DRAW;
                gap_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so requests register with the state.
    always_comb begin
        draw_start_d  = 1'b0;
        draw_clear_d  = 1'b0;
        draw_over_d   = 1'b0;
        draw_win_d    = 1'b0;
        draw_maze_d   = 1'b0;
        game_active_d = 1'b0;
        case (state_d)
            S_START_DRAW: draw_start_d  = 1'b1;
            S_CLEAR:      draw_clear_d  = 1'b1;
            S_OVER_DRAW:  draw_over_d   = 1'b1;
            S_WIN_DRAW:   draw_win_d    = 1'b1;
            S_MAZE:       draw_maze_d   = 1'b1;
            S_PLAY:       game_active_d = 1'b1;
            default:      ;
        endcase
    end

    assign drawStart    = draw_start_q;
    assign drawClear    = draw_clear_q;
    assign drawGameOver = draw_over_q;
    assign drawWinner   = draw_win_q;
    assign drawMaze     = draw_maze_q;
    assign gameActive   = game_active_q;
    assign level        = level_q;

    // Write enable stops as soon as the active drawer reports done.
    assign plotEn = ((draw_start_q | draw_clear_q | draw_over_q | draw_win_q) & ~screenDone)
                  | (draw_maze_q & ~mazeDone);

endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
Top-level screen FSM that sits directly upstream of the full-screen draw stage. It raises one of drawStart/drawClear/drawGameOver/drawWinner, holds it until that stage reports done, and requests the maze drawer. It also gates the VGA write enable, runs gameplay, counts levels and times how long the win and game-over screens stay up.

Parameters:
HOLD_CYCLES, 100000000, cycles a win/game-over screen stays up before advancing (2 s at 50 MHz); counter is 27 bits
NUM_LEVELS, 3, number of mazes; winning the last one returns to the start screen
GAP_CYCLES, 2, cycles with all draw requests low between consecutive screen draws

Ports:
clk  input  1  single system clock
reset  input  1  synchronous, active-high reset
startKey  input  1  raw asynchronous start button, active-high
screenDone  input  1  done from the full-screen draw stage
mazeDone  input  1  done pulse/level from the maze drawer
playerWon  input  1  player reached exit (sampled only in PLAY)
playerDead  input  1  time-out or collision (sampled only in PLAY)
drawStart  output  1  request start screen
drawClear  output  1  request blue clear of play area
drawGameOver  output  1  request game-over screen
drawWinner  output  1  request winner screen
drawMaze  output  1  request maze drawer for current level
plotEn  output  1  VGA write enable
gameActive  output  1  high only in PLAY
level  output  2  current maze index, 0..NUM_LEVELS-1

Behaviour:
- Reset: all outputs 0, level=0, hold/gap counters 0, state=GAP with next=START_DRAW, synchronizer flops 0.
- startKey: passes through a 2-flop synchronizer, then a rising-edge detector (a third flop). A press is seen 3 cycles after the input rises. Holding the key produces one event only.
- States:
  - GAP: all draw* low. Wait GAP_CYCLES, then go to the pending state. The gap guarantees the downstream done drops before the next request.
  - START_DRAW: drawStart=1 until screenDone=1. On that cycle drop drawStart and go to WAIT_KEY.
  - WAIT_KEY: key event sets level=0 and goes GAP->CLEAR.
  - CLEAR: drawClear=1 until screenDone, then GAP->MAZE.
  - MAZE: drawMaze=1 until mazeDone, then go to PLAY with no gap.
  - PLAY: gameActive=1. playerWon goes GAP->WIN_DRAW. playerDead goes GAP->OVER_DRAW. If both are high in the same cycle, won has priority.
  - WIN_DRAW/OVER_DRAW: hold drawWinner/drawGameOver until screenDone, then go to HOLD.
  - HOLD: the last screen's request stays low and the image stays on screen. A down-counter loads HOLD_CYCLES-1 on entry and leaves at 0.
    - Exit after a win: if level<NUM_LEVELS-1, level+=1 and GAP->CLEAR. Otherwise level=0 and GAP->START_DRAW.
    - Exit after game over: level=0, GAP->START_DRAW.
    - A key event in HOLD skips the remaining time.
- Exactly one of draw*/drawMaze is high at any time (one-hot or none). This is an invariant for the bench.
- plotEn = (any screen draw request & ~screenDone) | (drawMaze & ~mazeDone). It is combinational from registered requests.
- screenDone or mazeDone arriving in a state that does not expect it is ignored.
- Key events outside WAIT_KEY and HOLD are ignored and not queued.
- Reset asserted mid-draw takes effect next edge and drops every request. The downstream stage then sees its draw inputs low and clears its own done.
- level never exceeds NUM_LEVELS-1. It wraps only through START_DRAW.

Test Plan:
- Reset then release, screenDone pulsed 10 cycles after drawStart rises -> drawStart high from cycle GAP_CYCLES+1, falls on the screenDone cycle; state WAIT_KEY; plotEn low once screenDone is high.
- startKey raised for 20 cycles in WAIT_KEY -> one event; drawClear rises GAP_CYCLES cycles after the event; after screenDone, drawMaze rises; after mazeDone, gameActive=1, level=0.
- PLAY with playerWon=1 and playerDead=1 on the same cycle -> drawWinner (not drawGameOver). With HOLD_CYCLES=4, after screenDone the sequencer waits 4 cycles, then drawClear with level=1.
- Win three times (NUM_LEVELS=3) -> level 0->1->2; third win returns to drawStart with level=0.
- playerDead in PLAY at level 1 -> drawGameOver; after hold, drawStart, level=0. A key press during HOLD exits early on the event cycle.
- Assert reset while drawClear=1 and plotEn=1 -> next cycle all outputs 0. The one-hot invariant is checked every cycle for the whole run.
